// File: rtl/ntt_ctrl_pkg.sv
// ntt_ctrl_pkg
// Shared definitions for the radix-2 NTT stage sequencer:
//   - ctrl_state_t : sequencer FSM states
//   - pipe_depth() : read-to-write distance (RAM read latency + butterfly latency)
//   - bf_addr()    : butterfly operand / twiddle address formula for stage s, butterfly k
package ntt_ctrl_pkg;

  // Widest transform the address helper has to handle (N = 4096).
  localparam int MAX_LOGN = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_t;

  typedef struct packed {
    logic [MAX_LOGN-1:0] addr0;
    logic [MAX_LOGN-1:0] addr1;
    logic [MAX_LOGN-1:0] tw;
  } bf_addr_t;

  function automatic int pipe_depth(input int rd_lat, input int bf_lat);
    return rd_lat + bf_lat;
  endfunction

  // Butterfly k of stage s works on a group of 2m words (m = 2^s).
  // g selects the group and p the position inside the lower half;
  // the twiddle is the p-th power of the 2m-th root, expressed as an
  // index into an N/2-entry ROM of powers of the N-th root.
  function automatic bf_addr_t bf_addr(input logic [3:0]          logn,
                                       input logic [3:0]          s,
                                       input logic [MAX_LOGN-1:0] k);
    logic [MAX_LOGN-1:0] m;
    logic [MAX_LOGN-1:0] g;
    logic [MAX_LOGN-1:0] p;
    bf_addr_t            r;
    m       = MAX_LOGN'(1) << s;
    g       = k >> s;
    p       = k & (m - MAX_LOGN'(1));
    r.addr0 = (g << (s + 4'd1)) | p;
    r.addr1 = r.addr0 + m;
    r.tw    = p << (logn - 4'd1 - s);
    return r;
  endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// ntt_wb_delay
// Fixed-depth shift register that carries {valid, addr0, addr1} from the
// read side of the butterfly to the write side. Every stage is cleared by
// reset so no stale write can leak out after an abort.
// Ports:
//   clk     in  clock
//   reset   in  synchronous active-high clear of all stages
//   i_din   in  WIDTH  entry pushed every cycle
//   o_dout  out WIDTH  entry pushed DEPTH cycles earlier
module ntt_wb_delay #(
  parameter int DEPTH = 7,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/ntt2_stage_sequencer.sv
// ntt2_stage_sequencer
// Drives one pipelined modular butterfly through a full in-place radix-2
// DIT NTT (bit-reversed input) of N = 2^LOGN words. One butterfly is issued
// per cycle inside a stage; between stages the pipeline is drained so every
// write of stage s lands before stage s+1 reads anything.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a transform (only looked at when idle)
//   busy                  transform in progress, including the done cycle
//   done                  one-cycle pulse after the last write
//   stage                 current stage index
//   rd_en                 read strobe for both RAM ports
//   rd_addr0, rd_addr1    even / odd operand addresses
//   tw_addr               twiddle ROM address, aligned with rd_en
//   wr_en                 write strobe for both RAM ports
//   wr_addr0, wr_addr1    destinations of the sum / difference outputs
module ntt2_stage_sequencer
  import ntt_ctrl_pkg::*;
#(
  parameter int LOGN   = 8,
  parameter int BF_LAT = 6,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(LOGN)-1:0] stage,
  output logic                    rd_en,
  output logic [LOGN-1:0]         rd_addr0,
  output logic [LOGN-1:0]         rd_addr1,
  output logic [LOGN-2:0]         tw_addr,
  output logic                    wr_en,
  output logic [LOGN-1:0]         wr_addr0,
  output logic [LOGN-1:0]         wr_addr1
);

  localparam int PIPE = pipe_depth(RD_LAT, BF_LAT);
  localparam int SW   = $clog2(LOGN);
  localparam int KW   = LOGN - 1;
  localparam int DW   = $clog2(PIPE + 1);
  localparam int WBW  = 1 + 2 * LOGN;

  // k counts butterflies inside a stage; N/2-1 is all ones in KW bits.
  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);
  localparam logic [DW-1:0] D_LOAD = DW'(PIPE - 1);

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_nxt;
  logic [SW-1:0]    r_s;
  logic [SW-1:0]    w_s_nxt;
  logic [KW-1:0]    r_k;
  logic [KW-1:0]    w_k_nxt;
  logic [DW-1:0]    r_dcnt;
  logic [DW-1:0]    w_dcnt_nxt;

  logic             w_issue;
  bf_addr_t         w_addr;
  logic [WBW-1:0]   w_wb_in;
  logic [WBW-1:0]   w_wb_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_k     <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_k     <= w_k_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  // The drain counter is loaded with PIPE-1 on the last issue so DRAIN lasts
  // exactly PIPE cycles; the last write of the stage happens in its final cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_k_nxt     = r_k;
    w_dcnt_nxt  = r_dcnt;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_ISSUE;
          w_s_nxt     = '0;
          w_k_nxt     = '0;
        end
      end
      ST_ISSUE: begin
        if (r_k == K_LAST) begin
          w_state_nxt = ST_DRAIN;
          w_k_nxt     = '0;
          w_dcnt_nxt  = D_LOAD;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_dcnt == '0) begin
          if (r_s == S_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ISSUE;
            w_s_nxt     = r_s + 1'b1;
          end
        end else begin
          w_dcnt_nxt = r_dcnt - 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_s_nxt     = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_addr = bf_addr(4'(LOGN), 4'(r_s), MAX_LOGN'(r_k));
  end

  assign w_issue  = (r_state == ST_ISSUE);
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign stage    = r_s;
  assign rd_en    = w_issue;

  // Addresses are forced to 0 outside ISSUE so idle outputs (and invalid
  // delay-line entries) are all zero.
  assign rd_addr0 = w_issue ? w_addr.addr0[LOGN-1:0] : '0;
  assign rd_addr1 = w_issue ? w_addr.addr1[LOGN-1:0] : '0;
  assign tw_addr  = w_issue ? w_addr.tw[LOGN-2:0]    : '0;

  assign w_wb_in  = {w_issue, rd_addr0, rd_addr1};

  ntt_wb_delay #(
    .DEPTH (PIPE),
    .WIDTH (WBW)
  ) u_wb_delay (
    .clk    (clk),
    .reset  (reset),
    .i_din  (w_wb_in),
    .o_dout (w_wb_out)
  );

  assign wr_en    = w_wb_out[WBW-1];
  assign wr_addr0 = w_wb_out[2*LOGN-1:LOGN];
  assign wr_addr1 = w_wb_out[LOGN-1:0];

endmodule

// File: tb/tb_ntt2_stage_sequencer.sv
// tb_ntt2_stage_sequencer
// Two sequencer instances: a small one (LOGN=3) whose reads, writes and done
// pulse are checked against an expected-event scoreboard, and a default one
// (LOGN=8) that runs a full NTT on a behavioural RAM/butterfly model whose
// final RAM contents are compared against a direct O(N^2) transform.
module tb_ntt2_stage_sequencer;

  localparam int NS     = 8;
  localparam int PS     = 7;
  localparam int STGS   = NS / 2 + PS;
  localparam int DONES  = 1 + 3 * STGS;
  localparam int NL     = 256;
  localparam int DONEL  = 1 + 8 * (128 + 7);
  localparam int Q      = 7681;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // small instance signals
  logic       rstS, startS, busyS, doneS, rdEnS, wrEnS;
  logic [1:0] stageS, twS;
  logic [2:0] rdA0S, rdA1S, wrA0S, wrA1S;

  // large instance signals
  logic       rstL, startL, busyL, doneL, rdEnL, wrEnL;
  logic [2:0] stageL;
  logic [6:0] twL;
  logic [7:0] rdA0L, rdA1L, wrA0L, wrA1L;

  ntt2_stage_sequencer #(.LOGN(3), .BF_LAT(6), .RD_LAT(1)) dutS (
    .clk(clk), .reset(rstS), .start(startS), .busy(busyS), .done(doneS),
    .stage(stageS), .rd_en(rdEnS), .rd_addr0(rdA0S), .rd_addr1(rdA1S),
    .tw_addr(twS), .wr_en(wrEnS), .wr_addr0(wrA0S), .wr_addr1(wrA1S)
  );

  ntt2_stage_sequencer #(.LOGN(8), .BF_LAT(6), .RD_LAT(1)) dutL (
    .clk(clk), .reset(rstL), .start(startL), .busy(busyL), .done(doneL),
    .stage(stageL), .rd_en(rdEnL), .rd_addr0(rdA0L), .rd_addr1(rdA1L),
    .tw_addr(twL), .wr_en(wrEnL), .wr_addr0(wrA0L), .wr_addr1(wrA1L)
  );

  typedef struct {
    int cyc;
    int s;
    int a0;
    int a1;
    int tw;
  } xfer_t;

  typedef struct {
    int addr;
    int wcyc;
  } pend_t;

  typedef struct {
    longint sum;
    longint diff;
  } bf_t;

  xfer_t  rdQ[$];
  xfer_t  wrQ[$];
  int     doneQ[$];
  pend_t  pendQ[$];
  int     lastDoneS = -10;

  bf_t    bfQ[$];
  longint ram[NL];
  longint xv[NL];
  longint golden[NL];
  longint pw[NL];
  int     doneSeenL = 0;
  int     doneCycL = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportFail(input string name, input int info);
    total++;
    bad++;
    $display("[TB] FAIL %s: event at cycle %0d not matched (cycle %0d)", name, info, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected events for one small transform whose start is sampled at the
  // end of cycle c0: textbook Cooley-Tukey loops over groups and positions,
  // issued back to back with PS idle cycles between stages.
  task automatic pushTransform(input int c0);
    xfer_t e;
    int    idx;
    for (int s = 0; s < 3; s++) begin
      int len;
      len = 1 << s;
      idx = 0;
      for (int i = 0; i < NS; i += 2 * len) begin
        for (int j = 0; j < len; j++) begin
          e.cyc = c0 + 1 + s * STGS + idx;
          e.s   = s;
          e.a0  = i + j;
          e.a1  = i + j + len;
          e.tw  = j * (NS / (2 * len));
          rdQ.push_back(e);
          e.cyc = e.cyc + PS;
          wrQ.push_back(e);
          idx++;
        end
      end
    end
    doneQ.push_back(c0 + DONES);
  endtask

  task automatic flushAfter(input int lim);
    xfer_t r[$];
    xfer_t w[$];
    int    d[$];
    foreach (rdQ[i]) if (rdQ[i].cyc <= lim) r.push_back(rdQ[i]);
    foreach (wrQ[i]) if (wrQ[i].cyc <= lim) w.push_back(wrQ[i]);
    foreach (doneQ[i]) if (doneQ[i] <= lim) d.push_back(doneQ[i]);
    rdQ = r;
    wrQ = w;
    doneQ = d;
  endtask

  task automatic checkZeroS(input string tag);
    checkOutput({tag, "_busy"}, busyS, 0);
    checkOutput({tag, "_done"}, doneS, 0);
    checkOutput({tag, "_stage"}, stageS, 0);
    checkOutput({tag, "_rd_en"}, rdEnS, 0);
    checkOutput({tag, "_rd_addr0"}, rdA0S, 0);
    checkOutput({tag, "_rd_addr1"}, rdA1S, 0);
    checkOutput({tag, "_tw_addr"}, twS, 0);
    checkOutput({tag, "_wr_en"}, wrEnS, 0);
    checkOutput({tag, "_wr_addr0"}, wrA0S, 0);
    checkOutput({tag, "_wr_addr1"}, wrA1S, 0);
  endtask

  task automatic checkQueuesEmpty(input string tag);
    checkOutput({tag, "_reads_left"}, rdQ.size(), 0);
    checkOutput({tag, "_writes_left"}, wrQ.size(), 0);
    checkOutput({tag, "_done_left"}, doneQ.size(), 0);
  endtask

  // Start held for `hold` cycles (at most until the done cycle, so it is
  // never sampled again in IDLE).
  task automatic applyStimulus(input int hold);
    int c0;
    c0 = cyc;
    startS = 1'b1;
    pushTransform(c0);
    repeat (hold) tick();
    startS = 1'b0;
    while (cyc < c0 + DONES + 2) tick();
    checkQueuesEmpty("run");
  endtask

  // Reset during stage 0 drain (cycle 10): writes up to cycle 10 still
  // appear, everything later is discarded.
  task automatic applyMidReset();
    int c0;
    c0 = cyc;
    startS = 1'b1;
    pushTransform(c0);
    tick();
    startS = 1'b0;
    while (cyc < c0 + 10) tick();
    rstS = 1'b1;
    flushAfter(cyc);
    tick();
    rstS = 1'b0;
    #2;
    checkZeroS("after_abort");
    pendQ.delete();
    repeat (12) tick();
    checkQueuesEmpty("abort");
  endtask

  // Scoreboard monitor for the small instance.
  always @(negedge clk) begin
    xfer_t e;
    pend_t pk[$];
    int    hz;
    while (rdQ.size() > 0 && rdQ[0].cyc < cyc) begin
      reportFail("rd_missing", rdQ[0].cyc);
      void'(rdQ.pop_front());
    end
    while (wrQ.size() > 0 && wrQ[0].cyc < cyc) begin
      reportFail("wr_missing", wrQ[0].cyc);
      void'(wrQ.pop_front());
    end
    while (doneQ.size() > 0 && doneQ[0] < cyc) begin
      reportFail("done_missing", doneQ[0]);
      void'(doneQ.pop_front());
    end
    if (rdEnS === 1'b1) begin
      if (rdQ.size() == 0) begin
        reportFail("rd_unexpected", cyc);
      end else begin
        e = rdQ.pop_front();
        checkOutput("rd_cycle", cyc, e.cyc);
        checkOutput("rd_stage", stageS, e.s);
        checkOutput("rd_addr0", rdA0S, e.a0);
        checkOutput("rd_addr1", rdA1S, e.a1);
        checkOutput("rd_tw", twS, e.tw);
      end
      hz = 0;
      foreach (pendQ[i]) begin
        if (pendQ[i].wcyc >= cyc) begin
          pk.push_back(pendQ[i]);
          if (pendQ[i].addr == int'(rdA0S) || pendQ[i].addr == int'(rdA1S)) hz++;
        end
      end
      checkOutput("rd_hazard", hz, 0);
      pendQ = pk;
      pendQ.push_back('{addr: int'(rdA0S), wcyc: cyc + PS});
      pendQ.push_back('{addr: int'(rdA1S), wcyc: cyc + PS});
    end
    if (wrEnS === 1'b1) begin
      if (wrQ.size() == 0) begin
        reportFail("wr_unexpected", cyc);
      end else begin
        e = wrQ.pop_front();
        checkOutput("wr_cycle", cyc, e.cyc);
        checkOutput("wr_addr0", wrA0S, e.a0);
        checkOutput("wr_addr1", wrA1S, e.a1);
      end
    end
    if (doneS === 1'b1) begin
      if (doneQ.size() == 0) begin
        reportFail("done_unexpected", cyc);
      end else begin
        checkOutput("done_cycle", cyc, doneQ.pop_front());
      end
      checkOutput("busy_at_done", busyS, 1);
      lastDoneS = cyc;
    end else if (cyc == lastDoneS + 1) begin
      checkOutput("busy_after_done", busyS, 0);
    end
  end

  // Behavioural RAM + butterfly for the large instance: operands are read
  // in the rd_en cycle, results written back in the wr_en cycle.
  always @(negedge clk) begin
    bf_t    r;
    longint a;
    longint b;
    longint t;
    if (rdEnL === 1'b1) begin
      a = ram[rdA0L];
      b = ram[rdA1L];
      t = (pw[twL] * b) % Q;
      r.sum  = (a + t) % Q;
      r.diff = (a - t + Q) % Q;
      bfQ.push_back(r);
    end
    if (wrEnL === 1'b1) begin
      if (bfQ.size() == 0) begin
        reportFail("large_wr_unexpected", cyc);
      end else begin
        r = bfQ.pop_front();
        ram[wrA0L] = r.sum;
        ram[wrA1L] = r.diff;
      end
    end
    if (doneL === 1'b1) begin
      doneSeenL = doneSeenL + 1;
      doneCycL  = cyc;
    end
  end

  function automatic longint modPow(input longint b, input int e);
    longint r;
    longint x;
    r = 1;
    x = b % Q;
    for (int i = 0; i < e; i++) r = (r * x) % Q;
    return r;
  endfunction

  function automatic int bitRev8(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (((v >> i) & 1) != 0) r |= 1 << (7 - i);
    return r;
  endfunction

  task automatic applyLargeTransform();
    longint w;
    longint acc;
    int     c0;
    w = 0;
    for (int g = 2; g < Q; g++) begin
      w = modPow(g, (Q - 1) / NL);
      if (modPow(w, NL / 2) != 1) break;
    end
    pw[0] = 1;
    for (int i = 1; i < NL; i++) pw[i] = (pw[i-1] * w) % Q;
    for (int n = 0; n < NL; n++) begin
      xv[n] = longint'($urandom_range(0, Q - 1));
      ram[bitRev8(n)] = xv[n];
    end
    for (int k = 0; k < NL; k++) begin
      acc = 0;
      for (int n = 0; n < NL; n++) acc = (acc + xv[n] * pw[(n * k) % NL]) % Q;
      golden[k] = acc;
    end
    c0 = cyc;
    startL = 1'b1;
    tick();
    startL = 1'b0;
    while (doneSeenL == 0 && cyc < c0 + DONEL + 50) tick();
    checkOutput("large_done_seen", doneSeenL, 1);
    checkOutput("large_done_cycle", doneCycL - c0, DONEL);
    repeat (3) tick();
    checkOutput("large_busy_idle", busyL, 0);
    checkOutput("large_pipe_empty", bfQ.size(), 0);
    for (int i = 0; i < NL; i++) checkOutput("large_ram_word", 32'(ram[i]), 32'(golden[i]));
  endtask

  initial begin
    rstS = 1'b1;
    rstL = 1'b1;
    startS = 1'b0;
    startL = 1'b0;
    repeat (3) tick();
    rstS = 1'b0;
    rstL = 1'b0;
    checkZeroS("reset_state");
    checkOutput("large_reset_busy", busyL, 0);
    checkOutput("large_reset_wr_en", wrEnL, 0);

    applyStimulus(1);
    repeat ($urandom_range(0, 3)) tick();
    applyStimulus(DONES);
    applyStimulus($urandom_range(2, 20));
    repeat ($urandom_range(1, 4)) tick();
    applyMidReset();
    applyStimulus(1);

    applyLargeTransform();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
